serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: computes {bout, diff} = a - b - bin, LSB first,
//   one bit per clock through a single full-subtractor cell and a borrow flop.
//   Arithmetic inverse of the combinational full adder. Area-cheap datapath
//   element with a start/busy/done handshake for use by the sequential
//   arithmetic blocks.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; operands sampled on the accepting edge
//   a      in   WIDTH  minuend
//   b      in   WIDTH  subtrahend
//   bin    in   1      borrow-in
//   busy   out  1      high while a subtraction is in progress
//   done   out  1      one-cycle pulse: diff/bout valid
//   diff   out  WIDTH  difference (a - b - bin) mod 2^WIDTH
//   bout   out  1      borrow-out; 1 when a < b + bin (unsigned)
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, busy=0, done=0, diff=0,
//     bout=0, internal shift regs/borrow/count=0.
//   - FSM: IDLE -> SHIFT on start; SHIFT -> SHIFT while count < WIDTH-1;
//     SHIFT -> DONE on last bit; DONE -> SHIFT if start, else IDLE.
//   - start is accepted only in IDLE or DONE; ignored in SHIFT (no queueing).
//   - Accept edge: latch a->sa, b->sb, bin->br, count=0, busy=1 next cycle.
//   - Each SHIFT cycle (bit x=sa[0], y=sb[0]):
//       d      = x ^ y ^ br
//       br_nxt = (~x & y) | (~(x ^ y) & br)
//     sa, sb shift right by 1; d shifted into MSB of result shift reg; count++.
//   - After WIDTH SHIFT cycles: diff <= result reg, bout <= final br, state DONE.
//   - Latency: start sampled at edge N -> done=1 during cycle N+WIDTH+1 (9 for WIDTH=8).
//   - busy=1 exactly in SHIFT (WIDTH cycles); done=1 exactly in DONE (1 cycle).
//   - diff/bout change only on entry to DONE; held stable otherwise, including
//     through a following operation until its own DONE.
//   - Back-to-back: start in DONE cycle starts new op; done pulses, busy rises next cycle.
//   - Operand inputs are don't-care except on the accepting edge.
//   - Reset mid-SHIFT aborts: all state cleared, no done pulse, diff/bout=0.
//   - count width = $clog2(WIDTH); no wrap beyond WIDTH-1.
// STRUCTURE
//   - Package serial_arith_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;
//     shared by the sibling serial adder.
//   - Sub-module full_subtractor (x, y, bi -> d, bo): purely combinational cell,
//     instantiated once; FSM, shift registers and borrow flop in top module.
// TESTING
//   - Reset then idle: busy=0, done=0, diff=0x00, bout=0 for 20 cycles.
//   - a=10, b=3, bin=0 -> done at start+9, diff=0x07, bout=0; busy high 8 cycles.
//   - a=3, b=10, bin=0 -> diff=0xF9, bout=1. a=0, b=0, bin=1 -> diff=0xFF, bout=1.
//   - a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0; a=0x80, b=0x01 -> 0x7F, bout=0.
//   - start pulsed in 3rd SHIFT cycle with a=0x55 -> ignored, first result unchanged,
//     exactly one done pulse; start in DONE cycle -> second result 9 cycles later.
//   - rst asserted in 4th SHIFT cycle -> outputs 0 immediately (async), no done;
//     new op after release (a=200, b=100) -> diff=100, bout=0.
//   - Random sweep 1000 ops vs (a - b - bin) golden model, WIDTH=8 and WIDTH=5.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x outright, or when x == y and a borrow arrives.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout, diff} = a - b - bin, LSB first, one bit per clock.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    count;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (d),
    .bo (br_nxt)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_nxt = {d, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt;
          br  <= br_nxt;
          if (count == LAST) begin
            // Last bit: publish the result including the bit computed this cycle.
            diff  <= res_nxt;
            bout  <= br_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=5.
module tb_serial_subtractor;

  typedef struct packed {
    logic       bout;
    logic [7:0] diff;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start5 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       bin8 = 1'b0, bin5 = 1'b0;
  logic       busy8, done8, bout8, busy5, done5, bout5;
  logic [7:0] diff8;
  logic [4:0] diff5;

  exp_t q8[$];
  exp_t q5[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .bin(bin5),
    .busy(busy5), .done(done5), .diff(diff5), .bout(bout5)
  );

  // Golden model: plain integer subtraction, borrow taken from the bit above WIDTH.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin);
    exp_t e;
    int   r;
    int   m;
    m = (1 << w);
    r = int'(a % m) - int'(b % m) - int'(bin);
    e.bout = (r < 0);
    e.diff = 8'((r + m) % m);
    return e;
  endfunction

  task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    if (w == 8) begin
      start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    end else begin
      start5 = 1'b1; a5 = a[4:0]; b5 = b[4:0]; bin5 = bin;
    end
  endtask

  // Advance until done; operands are scrambled after acceptance since they are don't-care.
  task automatic wait_done(input int w, output int edges, output int busy_cnt, output bit got);
    edges = 0; busy_cnt = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        start8 = 1'b0; start5 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); a5 = 5'($urandom); b5 = 5'($urandom);
      end
      if ((w == 8) ? busy8 : busy5) busy_cnt++;
      if ((w == 8) ? done8 : done5) got = 1'b1;
    end
  endtask

  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input string name, input bit chk_lat);
    int   edges, busy_cnt;
    bit   got;
    exp_t e, obs;
    if (w == 8) q8.push_back(model(8, a, b, bin));
    else        q5.push_back(model(5, a, b, bin));
    @(negedge clk);
    drive(w, a, b, bin);
    wait_done(w, edges, busy_cnt, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required within %0d", name, edges, w + 1);
      if (w == 8) void'(q8.pop_front()); else void'(q5.pop_front());
    end else begin
      if (w == 8) begin
        e = q8.pop_front(); obs = {bout8, diff8};
      end else begin
        e = q5.pop_front(); obs = {bout5, 3'b000, diff5};
      end
      if (obs !== e) begin
        errors++;
        $display("FAIL %s result: got bout=%b diff=%h, required bout=%b diff=%h",
                 name, obs.bout, obs.diff, e.bout, e.diff);
      end
      if (chk_lat) begin
        checks++;
        if (edges !== w + 1 || busy_cnt !== w) begin
          errors++;
          $display("FAIL %s timing: done after %0d edges busy %0d cycles, required %0d and %0d",
                   name, edges, busy_cnt, w + 1, w);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, diff8, bout8, busy5, done5, diff5, bout5} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b, required all zero",
               {busy8, done8, diff8, bout8, busy5, done5, diff5, bout5});
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy8, done8, diff8, bout8, busy5, done5, diff5, bout5} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b, required all zero", i,
                 {busy8, done8, diff8, bout8, busy5, done5, diff5, bout5});
      end
    end
  endtask

  task automatic test_basic();
    do_op(8, 8'd10,  8'd3,   1'b0, "sub_10_3",    1'b1);
    do_op(8, 8'd3,   8'd10,  1'b0, "sub_3_10",    1'b1);
    do_op(8, 8'h00,  8'h00,  1'b1, "sub_0_0_b1",  1'b1);
    do_op(8, 8'hFF,  8'hFF,  1'b0, "sub_ff_ff",   1'b1);
    do_op(8, 8'h80,  8'h01,  1'b0, "sub_80_01",   1'b1);
    do_op(5, 8'd31,  8'd0,   1'b1, "w5_31_0_b1",  1'b1);
    do_op(5, 8'd0,   8'd31,  1'b1, "w5_0_31_b1",  1'b1);
  endtask

  task automatic test_back_to_back();
    int   edges;
    int   dones;
    bit   got;
    exp_t e;
    q8.push_back(model(8, 8'd10, 8'd3, 1'b0));
    @(negedge clk);
    drive(8, 8'd10, 8'd3, 1'b0);
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) start8 = 1'b0;
      // A start during the 3rd shift cycle must be dropped.
      if (edges == 3) drive(8, 8'h55, 8'h00, 1'b0);
      if (edges == 4) start8 = 1'b0;
      if (done8) got = 1'b1;
    end
    e = q8.pop_front();
    checks++;
    if (!got || edges !== 9 || {bout8, diff8} !== e) begin
      errors++;
      $display("FAIL ignore_start: got done=%b at %0d bout=%b diff=%h, required at 9 bout=%b diff=%h",
               got, edges, bout8, diff8, e.bout, e.diff);
    end
    // Restart straight out of the DONE cycle.
    q8.push_back(model(8, 8'h80, 8'h01, 1'b0));
    drive(8, 8'h80, 8'h01, 1'b0);
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || diff8 !== 8'h07) begin
          errors++;
          $display("FAIL b2b_hold: got busy=%b done=%b diff=%h, required 1 0 07", busy8, done8, diff8);
        end
      end
      if (done8) got = 1'b1;
    end
    e = q8.pop_front();
    checks++;
    if (!got || edges !== 9 || {bout8, diff8} !== e) begin
      errors++;
      $display("FAIL b2b_result: got done=%b at %0d bout=%b diff=%h, required at 9 bout=%b diff=%h",
               got, edges, bout8, diff8, e.bout, e.diff);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL extra_done: got %0d further done pulses, required 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    drive(8, 8'h12, 8'h34, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, diff8, bout8} !== '0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b done=%b diff=%h bout=%b, required all zero",
               busy8, done8, diff8, bout8);
    end
    @(negedge clk) rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d cycles of busy/done after abort, required 0", dones);
    end
    do_op(8, 8'd200, 8'd100, 1'b0, "after_reset", 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), "rand_w8", 1'b0);
    for (int i = 0; i < 1000; i++)
      do_op(5, 8'($urandom), 8'($urandom), 1'($urandom), "rand_w5", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
